trace_encoder: RTL and testbench

Debug trace encoder for the McCoy core. It observes the per-instruction control vector produced by the opcode decoder and maps it back to a 3-bit opcode, which is the inverse of decoding. Each result is buffered in a small FIFO and shifted out as framed serial packets on a single output pin. The block sits beside the decoder, taps its outputs, and drives one spare chip output so program flow can be reconstructed off-chip.

---
 rtl/trace_encoder.sv | 195 +++++++++++++++++++
 tb/tb_trace_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_encoder.sv
// Debug trace encoder: maps decoder control vectors back to 3-bit opcodes, queues
// them in a small FIFO and shifts them out as parity-protected serial frames.
module trace_encoder #(
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic                     valid,
  input  logic                     bez,
  input  logic                     ja,
  input  logic                     op1,
  input  logic [1:0]               op2,
  input  logic                     writeReg,
  input  logic                     writex8,
  input  logic [1:0]               x8Sel,
  input  logic                     clr_ovf,
  output logic                     tx_data,
  output logic                     tx_busy,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, STOP} state_t;

  // Entry layout {ill, amb, op[2:0]}; add and lr share a vector, hence amb.
  function automatic logic [4:0] encode(input logic [8:0] v);
    logic [4:0] e;
    case (v)
      9'b1_0_0_01_0_0_00: e = 5'b0_0_000;
      9'b0_0_0_00_0_1_01: e = 5'b0_0_001;
      9'b0_1_1_01_0_0_00: e = 5'b0_0_010;
      9'b0_0_0_00_0_1_00: e = 5'b0_1_011;
      9'b0_0_1_00_0_1_10: e = 5'b0_0_101;
      9'b0_0_0_00_1_0_00: e = 5'b0_0_110;
      9'b0_0_0_00_0_0_00: e = 5'b0_0_111;
      default:            e = 5'b1_0_111;
    endcase
    return e;
  endfunction

  function automatic logic parity(input logic [4:0] e);
    return ^e;
  endfunction

  // Bit 0 goes out first: start, op[0..2], amb, ill, parity.
  function automatic logic [6:0] frame(input logic [4:0] e);
    return {parity(e), e[4], e[3], e[2:0], 1'b1};
  endfunction

  logic [4:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          ovf_r;
  logic [7:0]    drop_cnt_r;
  state_t        state_r, state_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic [2:0]    bit_r, bit_next_s;
  logic [6:0]    shreg_r, shreg_next_s;
  logic          tx_data_r, tx_next_s;
  logic          tx_busy_r;
  logic          pop_s, push_req_s, push_s, drop_s, full_s, empty_s;
  logic [4:0]    entry_s;

  assign entry_s    = encode({bez, ja, op1, op2, writeReg, writex8, x8Sel});
  assign push_req_s = valid & trace_en;
  assign full_s     = (level_r == LW'(DEPTH));
  assign empty_s    = (level_r == {LW{1'b0}});
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;

  // FIFO storage; contents need no reset since the level qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Overflow flag and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      ovf_r      <= 1'b1;
      drop_cnt_r <= clr_ovf ? 8'd1 : ((drop_cnt_r == 8'hFF) ? 8'hFF : drop_cnt_r + 8'd1);
    end else if (clr_ovf) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      ovf_r      <= ovf_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // Serializer next-state, pop and next line value.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    bit_next_s   = bit_r;
    shreg_next_s = shreg_r;
    tx_next_s    = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          shreg_next_s = frame(mem_r[rd_ptr_r]);
          tx_next_s    = 1'b1;
          cnt_next_s   = {CW{1'b0}};
          bit_next_s   = 3'd0;
          state_next_s = SEND;
        end else begin
          tx_next_s = 1'b0;
        end
      end
      SEND: begin
        tx_next_s = shreg_r[0];
        if (cnt_r == CW'(BIT_CYCLES - 1)) begin
          cnt_next_s = {CW{1'b0}};
          if (bit_r == 3'd6) begin
            state_next_s = STOP;
            tx_next_s    = 1'b0;
          end else begin
            bit_next_s   = bit_r + 3'd1;
            shreg_next_s = {1'b0, shreg_r[6:1]};
            tx_next_s    = shreg_r[1];
          end
        end else begin
          cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (cnt_r == CW'(BIT_CYCLES - 1)) begin
          cnt_next_s   = {CW{1'b0}};
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Serializer registers; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_r     <= 3'd0;
      shreg_r   <= 7'd0;
      tx_data_r <= 1'b0;
      tx_busy_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bit_r     <= bit_next_s;
      shreg_r   <= shreg_next_s;
      tx_data_r <= tx_next_s;
      tx_busy_r <= (state_next_s != IDLE);
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_busy    = tx_busy_r;
  assign ovf        = ovf_r;
  assign drop_cnt   = drop_cnt_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_trace_encoder.sv
// Bench for trace_encoder: directed opcode table, overflow/saturation sequences,
// randomized traffic against a queue/countdown model, and a BIT_CYCLES=3 reset case.
module tb_trace_encoder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst1 = 1'b0, rst3 = 1'b0;
  logic trace_en = 1'b0, valid = 1'b0, clr_ovf = 1'b0;
  logic bez = 1'b0, ja = 1'b0, op1 = 1'b0, writeReg = 1'b0, writex8 = 1'b0;
  logic [1:0] op2 = 2'd0, x8Sel = 2'd0;
  logic tx1, busy1, ovf1, tx3, busy3, ovf3;
  logic [7:0] drop1, drop3;
  logic [2:0] level1, level3;

  always #5 clk = ~clk;

  trace_encoder #(.DEPTH(DEPTH), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1), .trace_en(trace_en), .valid(valid),
    .bez(bez), .ja(ja), .op1(op1), .op2(op2), .writeReg(writeReg),
    .writex8(writex8), .x8Sel(x8Sel), .clr_ovf(clr_ovf),
    .tx_data(tx1), .tx_busy(busy1), .ovf(ovf1), .drop_cnt(drop1), .fifo_level(level1));

  trace_encoder #(.DEPTH(DEPTH), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3), .trace_en(trace_en), .valid(valid),
    .bez(bez), .ja(ja), .op1(op1), .op2(op2), .writeReg(writeReg),
    .writex8(writex8), .x8Sel(x8Sel), .clr_ovf(clr_ovf),
    .tx_data(tx3), .tx_busy(busy3), .ovf(ovf3), .drop_cnt(drop3), .fifo_level(level3));

  typedef struct {
    logic [8:0] vec;    // {bez, ja, op1, op2, writeReg, writex8, x8Sel}
    logic [4:0] entry;  // {ill, amb, op}
  } row_t;

  row_t rows[8];
  int checks = 0, failures = 0;

  // Reference model state (dut1, BIT_CYCLES=1)
  int mlevel = 0, mbusy = 0, mdrop = 0;
  bit movf = 1'b0;
  logic [4:0] efq[$];
  // Frame receiver state
  int rxpos = -1, rx_count = 0;
  logic [6:0] rxbuf = 7'd0, rx_last = 7'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] menc(input logic [8:0] v);
    for (int i = 0; i < 8; i++) if (rows[i].vec == v) return rows[i].entry;
    return 5'b1_0_111;
  endfunction

  function automatic logic [6:0] mframe(input logic [4:0] e);
    logic [6:0] f;
    f[0] = 1'b1;
    f[1] = e[0]; f[2] = e[1]; f[3] = e[2];
    f[4] = e[3]; f[5] = e[4];
    f[6] = e[0] ^ e[1] ^ e[2] ^ e[3] ^ e[4];
    return f;
  endfunction

  task automatic set_vec(input logic [8:0] v);
    {bez, ja, op1, op2, writeReg, writex8, x8Sel} = v;
  endtask

  // One clock: advance the model on the current inputs, clock, then check dut1.
  task automatic tick();
    bit pop, acc, rst_s;
    rst_s = rst1;
    if (!rst_s) begin
      mlevel = 0; mbusy = 0; movf = 1'b0; mdrop = 0; efq.delete();
    end else begin
      pop = (mbusy == 0) && (mlevel > 0);
      if (mbusy > 0) mbusy--;
      acc = 1'b1;
      if (valid && trace_en) acc = (mlevel < DEPTH) || pop;
      if (pop) begin mlevel--; mbusy = 8; end
      if (valid && trace_en && acc) begin
        mlevel++;
        efq.push_back(menc({bez, ja, op1, op2, writeReg, writex8, x8Sel}));
      end
      if (valid && trace_en && !acc) begin
        movf = 1'b1;
        mdrop = clr_ovf ? 1 : ((mdrop < 255) ? mdrop + 1 : 255);
      end else if (clr_ovf) begin
        movf = 1'b0; mdrop = 0;
      end
    end
    @(posedge clk);
    #1;
    check("level", int'(level1), mlevel);
    check("ovf", int'(ovf1), int'(movf));
    check("drop_cnt", int'(drop1), mdrop);
    check("tx_busy", int'(busy1), int'(mbusy > 0));
    if (!rst_s) begin
      rxpos = -1;
      check("tx_reset", int'(tx1), 0);
    end else if (rxpos < 0) begin
      if (tx1) begin rxbuf[0] = 1'b1; rxpos = 1; end
    end else if (rxpos < 7) begin
      rxbuf[rxpos] = tx1; rxpos++;
    end else begin
      check("stop_bit", int'(tx1), 0);
      rx_count++;
      rx_last = rxbuf;
      if (efq.size() == 0) check("unexpected_frame", int'(rxbuf), -1);
      else check("frame", int'(rxbuf), int'(mframe(efq.pop_front())));
      rxpos = -1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mlevel != 0 || mbusy != 0 || rxpos >= 0) && n < 300) begin tick(); n++; end
    check("idle_timeout", int'(n >= 300), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] f;
    int base, n;
    rows[0] = '{9'b1_0_0_01_0_0_00, 5'b0_0_000};
    rows[1] = '{9'b0_0_0_00_0_1_01, 5'b0_0_001};
    rows[2] = '{9'b0_1_1_01_0_0_00, 5'b0_0_010};
    rows[3] = '{9'b0_0_0_00_0_1_00, 5'b0_1_011};
    rows[4] = '{9'b0_0_1_00_0_1_10, 5'b0_0_101};
    rows[5] = '{9'b0_0_0_00_1_0_00, 5'b0_0_110};
    rows[6] = '{9'b0_0_0_00_0_0_00, 5'b0_0_111};
    rows[7] = '{9'b1_1_0_00_0_0_00, 5'b1_0_111};

    // Reset and idle
    #1;
    repeat (3) tick();
    rst1 = 1'b1; rst3 = 1'b1; trace_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_tx", int'(tx1), 0);
      check("idle_level", int'(level1), 0);
    end

    // Single bez with exact waveform and 2-cycle start latency
    f = mframe(rows[0].entry);
    set_vec(rows[0].vec); valid = 1'b1;
    tick();
    valid = 1'b0;
    check("bez_level_after_push", int'(level1), 1);
    check("bez_tx_before_start", int'(tx1), 0);
    for (int b = 0; b < 8; b++) begin
      tick();
      check("bez_bit", int'(tx1), (b < 7) ? int'(f[b]) : 0);
    end
    wait_idle();

    // Opcode sweep
    for (int i = 0; i < 8; i++) begin
      set_vec(rows[i].vec); valid = 1'b1;
      tick();
      valid = 1'b0;
      base = rx_count;
      wait_idle();
      check("sweep_count", rx_count - base, 1);
      check("sweep_frame", int'(rx_last), int'(mframe(rows[i].entry)));
    end

    // Overflow: 8 back-to-back valids
    set_vec(rows[3].vec);
    base = rx_count;
    valid = 1'b1;
    repeat (8) tick();
    valid = 1'b0;
    check("ovf_flag", int'(ovf1), 1);
    check("ovf_drops", int'(drop1), 3);
    wait_idle();
    check("ovf_frames", rx_count - base, 5);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", int'(ovf1), 0);
    check("clr_drop", int'(drop1), 0);

    // Saturation, then clear colliding with a drop
    set_vec(rows[5].vec); valid = 1'b1;
    repeat (380) tick();
    check("sat_drop", int'(drop1), 255);
    n = 0;
    while (!(mbusy > 0 && mlevel == DEPTH) && n < 20) begin tick(); n++; end
    check("collide_setup_timeout", int'(n >= 20), 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; valid = 1'b0;
    check("collide_ovf", int'(ovf1), 1);
    check("collide_drop", int'(drop1), 1);
    wait_idle();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_vec(($urandom_range(0, 1) == 0) ? rows[$urandom_range(0, 7)].vec : 9'($urandom));
      valid    = ($urandom_range(0, 2) == 0);
      trace_en = ($urandom_range(0, 4) != 0);
      clr_ovf  = ($urandom_range(0, 31) == 0);
      tick();
    end
    valid = 1'b0; clr_ovf = 1'b0; trace_en = 1'b1;
    wait_idle();
    check("rand_all_frames_out", efq.size(), 0);

    // BIT_CYCLES=3: bits held 3 cycles, reset during bit 3
    rst3 = 1'b0; tick(); tick(); rst3 = 1'b1;
    f = mframe(rows[2].entry);
    set_vec(rows[2].vec); valid = 1'b1;
    tick(); tick();
    valid = 1'b0;
    check("bc3_busy", int'(busy3), 1);
    for (int k = 0; k < 9; k++) begin
      check("bc3_bit", int'(tx3), int'(f[k / 3]));
      tick();
    end
    check("bc3_level_before_rst", int'(level3), 1);
    rst3 = 1'b0;
    tick();
    check("bc3_rst_tx", int'(tx3), 0);
    check("bc3_rst_busy", int'(busy3), 0);
    check("bc3_rst_level", int'(level3), 0);
    rst3 = 1'b1;
    repeat (4) tick();
    check("bc3_idle_tx", int'(tx3), 0);
    check("bc3_idle_level", int'(level3), 0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
